// File: rtl/cla_share_arb.sv
// cla_share_arb: shares one external carry-lookahead adder among NUM_REQ requesters, one op in flight.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default build is round-robin.
module cla_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b,
  input  logic [NUM_REQ-1:0]          req_cin,
  output logic [WIDTH-1:0]            add_a,
  output logic [WIDTH-1:0]            add_b,
  output logic                        add_cin,
  input  logic [WIDTH-1:0]            add_s,
  input  logic                        add_cout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_cout
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_grant_found;
  logic [IDW-1:0]   w_grant_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;

  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_cin;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] r_rr_ptr;

  // Pointer holds the last served requester; the search starts just after it.
  always_ff @(posedge clk) begin
    if (rst)
      r_rr_ptr <= IDW'(NUM_REQ - 1);
    else if (r_state == EXEC)
      r_rr_ptr <= r_rsp_id;
  end

  always_comb begin
    int cand;
    cand          = 0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(r_rr_ptr) + k;
      if (cand >= NUM_REQ)
        cand = cand - NUM_REQ;
      if (req_valid[IDW'(cand)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDW'(cand);
      end
    end
  end
`endif

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_sel_a   = req_a[i*WIDTH +: WIDTH];
        w_sel_b   = req_b[i*WIDTH +: WIDTH];
        w_sel_cin = req_cin[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  // Grant is suppressed while reset is asserted so no requester sees a phantom accept.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_found && !rst) begin
          req_ready    = NUM_REQ'(1) << w_grant_idx;
          w_next_state = EXEC;
        end
      end
      EXEC: w_next_state = RESP;
      RESP: begin
        if (rsp_ready)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_found) begin
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_add_cin <= w_sel_cin;
            r_rsp_id  <= w_grant_idx;
          end
        end
        EXEC: begin
          r_rsp_sum   <= add_s;
          r_rsp_cout  <= add_cout;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready)
            r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_cla_share_arb.sv
// tb_cla_share_arb: scoreboard bench for cla_share_arb; a behavioural arbiter/adder model predicts
// each grant and response, and a separate monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_cla_share_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;
  logic [NUM_REQ-1:0]       req_cin = '0;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_s;
  logic                     add_cout;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;

  typedef struct {
    int id;
    int sum;
    int cout;
    int grantCyc;
    bit seen;
  } expect_t;

  expect_t          scoreQ[$];
  int               grantLog[$];
  int               checkCount = 0;
  int               passCount  = 0;
  int               cyc        = 0;
  bit               pend[NUM_REQ];
  logic [WIDTH-1:0] opA[NUM_REQ];
  logic [WIDTH-1:0] opB[NUM_REQ];
  logic             opC[NUM_REQ];
  bit               rstDrive      = 1'b1;
  bit               rspReadyDrive = 1'b1;
  bit               keepAll       = 1'b0;
  bit               randomFill    = 1'b0;
  bit               busy          = 1'b0;
  bit               releaseSeen   = 1'b0;
  int               lastServed    = NUM_REQ - 1;
  int               lastGrant     = -1;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // The shared adder itself lives outside the arbiter.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  cla_share_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
  endtask

  function automatic int modelGrant(input logic [NUM_REQ-1:0] v);
    if (v == '0)
      return -1;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++)
      if (v[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(lastServed + k) % NUM_REQ]) return (lastServed + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic loadOp(input int i, input int a, input int b, input int c);
    pend[i] = 1'b1;
    opA[i]  = WIDTH'(a);
    opB[i]  = WIDTH'(b);
    opC[i]  = c[0];
  endtask

  // One clock of stimulus: drive at the falling edge, check the combinational grant 1ns later.
  task automatic applyStimulus();
    int expG;
    int actG;
    int t;
    @(negedge clk);
    if (releaseSeen) begin
      busy        = 1'b0;
      releaseSeen = 1'b0;
    end
    if (randomFill) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(3) == 0)
          loadOp(i, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
        else if (pend[i] && $urandom_range(31) == 0)
          pend[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(2) != 0);
    end else begin
      rsp_ready = rspReadyDrive;
    end
    rst = rstDrive;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]              = pend[i];
      req_a[i*WIDTH +: WIDTH]   = opA[i];
      req_b[i*WIDTH +: WIDTH]   = opB[i];
      req_cin[i]                = opC[i];
    end
    #1;
    expG = (rst || busy) ? -1 : modelGrant(req_valid);
    checkOutput("req_ready", 32'(req_ready), (expG < 0) ? 32'd0 : (32'd1 << expG));
    actG = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_ready[i]) actG = i;
    lastGrant = actG;
    if (actG >= 0)
      grantLog.push_back(actG);
    if (rst) begin
      busy        = 1'b0;
      releaseSeen = 1'b0;
      scoreQ.delete();
      lastServed  = NUM_REQ - 1;
    end else if (expG >= 0) begin
      t = int'(opA[expG]) + int'(opB[expG]) + int'(opC[expG]);
      scoreQ.push_back('{id: expG, sum: t % (1 << WIDTH), cout: t >> WIDTH, grantCyc: cyc, seen: 1'b0});
      busy       = 1'b1;
      lastServed = expG;
      if (keepAll)
        loadOp(expG, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
      else
        pend[expG] = 1'b0;
    end
  endtask

  task automatic runUntilIdle(input int budget);
    bit anyPend;
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
      anyPend = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        if (pend[i]) anyPend = 1'b1;
    end while ((busy || releaseSeen || anyPend) && n < budget);
    if (busy || releaseSeen || anyPend)
      checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulseReset();
    rstDrive = 1'b1;
    repeat (2) applyStimulus();
    rstDrive = 1'b0;
  endtask

  // Monitor: compares the head of the scoreboard every cycle rsp_valid is up, pops on handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst === 1'b0 && rsp_valid === 1'b1) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        if (!scoreQ[0].seen) begin
          checkOutput("latency", 32'(cyc - scoreQ[0].grantCyc), 32'd2);
          scoreQ[0].seen = 1'b1;
        end
        checkOutput("rsp_id", 32'(rsp_id), 32'(scoreQ[0].id));
        checkOutput("rsp_sum", 32'(rsp_sum), 32'(scoreQ[0].sum));
        checkOutput("rsp_cout", 32'(rsp_cout), 32'(scoreQ[0].cout));
        if (rsp_ready) begin
          void'(scoreQ.pop_front());
          releaseSeen = 1'b1;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++)
      loadOp(i, i + 1, i + 2, 0);

    // Reset held with every requester asking: nothing may be granted or driven.
    repeat (3) begin
      applyStimulus();
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_add_a", 32'(add_a), 32'd0);
      checkOutput("rst_add_b", 32'(add_b), 32'd0);
      checkOutput("rst_add_cin", 32'(add_cin), 32'd0);
    end
    rstDrive = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      pend[i] = 1'b0;

    loadOp(0, 55, 8'h0F, 0);
    runUntilIdle(40);
    checkOutput("t2_sum", 32'(rsp_sum), 32'd70);
    checkOutput("t2_cout", 32'(rsp_cout), 32'd0);
    checkOutput("t2_id", 32'(rsp_id), 32'd0);

    loadOp(1, 8'hFF, 8'h01, 0);
    runUntilIdle(40);
    checkOutput("t3_sum", 32'(rsp_sum), 32'h00);
    checkOutput("t3_cout", 32'(rsp_cout), 32'd1);
    checkOutput("t3_id", 32'(rsp_id), 32'd1);

    rspReadyDrive = 1'b0;
    loadOp(2, 8'hAA, 8'h55, 1);
    repeat (8) applyStimulus();
    checkOutput("t4_held_valid", 32'(rsp_valid), 32'd1);
    rspReadyDrive = 1'b1;
    runUntilIdle(40);
    checkOutput("t4_sum", 32'(rsp_sum), 32'h00);
    checkOutput("t4_cout", 32'(rsp_cout), 32'd1);
    checkOutput("t4_id", 32'(rsp_id), 32'd2);

    pulseReset();
    grantLog.delete();
    keepAll = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      loadOp(i, 16 * i + 3, 200 - i, i % 2);
    repeat (16) applyStimulus();
    keepAll = 1'b0;
    runUntilIdle(80);
    checkOutput("t5_grant_count_ge5", 32'(grantLog.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < grantLog.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      checkOutput("t5_grant_order", 32'(grantLog[k]), 32'd0);
`else
      checkOutput("t5_grant_order", 32'(grantLog[k]), 32'(k % NUM_REQ));
`endif
    end

    loadOp(1, 10, 20, 0);
    runUntilIdle(40);
    loadOp(2, 30, 40, 1);
    lastGrant = -1;
    for (int n = 0; n < 10 && lastGrant != 2; n++)
      applyStimulus();
    checkOutput("t6_grant2", 32'(lastGrant), 32'd2);
    rstDrive = 1'b1;
    applyStimulus();
    rstDrive = 1'b0;
    grantLog.delete();
    loadOp(0, 1, 2, 0);
    loadOp(3, 3, 4, 1);
    applyStimulus();
    checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    runUntilIdle(40);
    checkOutput("t6_first_grant", (grantLog.size() > 0) ? 32'(grantLog[0]) : 32'hFFFF_FFFF, 32'd0);

    randomFill = 1'b1;
    repeat (400) applyStimulus();
    randomFill = 1'b0;
    rspReadyDrive = 1'b1;
    runUntilIdle(80);
    checkOutput("queue_empty", 32'(scoreQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
